// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the EX stage.
// An accepted MULT/MULTU/DIV/DIVU holds busy for N cycles, then commits
// HI/LO and pulses done. MTHI/MTLO write HI/LO directly while idle.
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned DW      = 2 * WIDTH;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   hi_d, lo_d;
  logic               busy_d, done_d;
  logic               load;

  // Latched operands; op_q[1] selects divide, op_q[0] selects unsigned.
  logic [WIDTH-1:0]   a_q, b_q;
  logic [1:0]         op_q;

  // Products: sign-extending to DW bits makes the low DW bits of an
  // unsigned multiply equal to the signed product.
  logic [DW-1:0]      prod_s, prod_u;
  // Divide on magnitudes, then restore signs.
  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   mag_a, mag_b, div_b, uq, ur, quo, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign stall = busy | (start & ~op[2]);

  assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  assign a_neg  = ~op_q[0] & a_q[WIDTH-1];
  assign b_neg  = ~op_q[0] & b_q[WIDTH-1];
  assign b_zero = (b_q == '0);
  assign mag_a  = a_neg ? (~a_q) + WIDTH'(1) : a_q;
  assign mag_b  = b_neg ? (~b_q) + WIDTH'(1) : b_q;
  // Substitute divisor keeps the divider well-defined when b is zero.
  assign div_b  = b_zero ? WIDTH'(1) : mag_b;
  assign uq     = mag_a / div_b;
  assign ur     = mag_a % div_b;
  // Most-negative / -1 wraps back to the dividend with remainder 0.
  assign quo    = (a_neg ^ b_neg) ? WIDTH'(0) - uq : uq;
  assign rem    = a_neg ? WIDTH'(0) - ur : ur;

  // Result selection from the latched opcode.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (!op_q[1]) begin
      res_hi = op_q[0] ? prod_u[DW-1:WIDTH] : prod_s[DW-1:WIDTH];
      res_lo = op_q[0] ? prod_u[WIDTH-1:0]  : prod_s[WIDTH-1:0];
    end else if (b_zero) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  // Next-state, counter and HI/LO update.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi;
    lo_d    = lo;
    busy_d  = busy;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (!op[2]) begin
            load    = 1'b1;
            state_d = RUN;
            busy_d  = 1'b1;
            count_d = op[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      RUN: begin
        if (count_q == '0) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi      <= hi_d;
      lo      <= lo_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Operand capture on issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (load) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op[1:0];
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO commits
// tagged with the clock edge they should appear at; a monitor checks them.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  logic        s2;
  logic [2:0]  op2;
  logic [15:0] a2, b2;
  logic        busy2, done2, stall2;
  logic [15:0] hi2, lo2;

  md_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .start(s2), .op(op2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .stall(stall2), .hi(hi2), .lo(lo2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          md;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  int          busy_until = -1;
  int          t_last = -100;
  int          n_last = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, expv);
    end
  endtask

  // Reference: full-width arithmetic straight from the instruction definitions.
  function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      p;
    int          sx, sy;
    logic [63:0] u;
    case (o)
      3'd0: begin
        p = longint'($signed(x)) * longint'($signed(y));
        return 64'(p);
      end
      3'd1: begin
        u = {32'd0, x} * {32'd0, y};
        return u;
      end
      3'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, x};
        sx = $signed(x);
        sy = $signed(y);
        return {32'(sx % sy), 32'(sx / sy)};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Drive one cycle of stimulus (called at posedge+1), update model, check busy/stall.
  task automatic drive(input bit s, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int          e, n;
    logic [63:0] r;
    bit          busy_e;
    start = s; op = o; a = x; b = y;
    e = cyc + 1;
    if (s && e > busy_until) begin
      if (o <= 3'd3) begin
        n = o[1] ? 10 : 5;
        r = ref_md(o, x, y);
        m_hi = r[63:32];
        m_lo = r[31:0];
        exp_q.push_back('{e + n, 1'b1, m_hi, m_lo});
        t_last = e;
        n_last = n;
        busy_until = e + n;
      end else if (o == 3'd4) begin
        m_hi = x;
        exp_q.push_back('{e, 1'b0, m_hi, m_lo});
      end else if (o == 3'd5) begin
        m_lo = x;
        exp_q.push_back('{e, 1'b0, m_hi, m_lo});
      end
    end
    busy_e = (cyc >= t_last) && (cyc < t_last + n_last);
    #1;
    check("busy", 32'(busy), 32'(busy_e));
    check("stall", 32'(stall), 32'(busy_e | (s && o <= 3'd3)));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  // Monitor: edge counter and commit/done checks.
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] last_hi = '0, last_lo = '0;
  always @(negedge clk) begin
    exp_t        it;
    bit          exp_done;
    logic [31:0] eh, el;
    if (!reset) begin
      last_hi = '0;
      last_lo = '0;
    end else begin
      exp_done = 1'b0;
      eh = last_hi;
      el = last_lo;
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        it = exp_q.pop_front();
        exp_done = it.md;
        eh = it.hi;
        el = it.lo;
      end
      check("done", 32'(done), 32'(exp_done));
      check("hi", hi, eh);
      check("lo", lo, el);
      check("busy_and_done", 32'(busy & done), 32'd0);
      last_hi = eh;
      last_lo = el;
    end
  end

  function automatic logic [31:0] rnd_a();
    case ($urandom % 8)
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 50));
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rnd_b();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    s2 = 1'b0; op2 = '0; a2 = '0; b2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    idle(2);

    // MTHI, then MULT/MULTU/DIV/DIVU and divide corner cases.
    drive(1'b1, 3'd4, 32'h1234_5678, 32'd0);
    idle(2);
    drive(1'b1, 3'd0, 32'd7, 32'hFFFF_FFFD);          idle(6);
    drive(1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2);          idle(6);
    drive(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2);          idle(11);
    drive(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2);          idle(11);
    drive(1'b1, 3'd2, 32'h55, 32'd0);                 idle(11);
    drive(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);  idle(11);
    drive(1'b1, 3'd5, 32'h0BAD_F00D, 32'd0);          idle(1);

    // Starts while running are ignored.
    drive(1'b1, 3'd0, 32'd12345, 32'd678);
    idle(1);
    drive(1'b1, 3'd5, 32'h0000_AAAA, 32'd0);
    drive(1'b1, 3'd0, 32'd3, 32'd3);
    idle(6);

    // Reset aborts an in-flight DIV.
    drive(1'b1, 3'd2, 32'd1000, 32'd7);
    idle(3);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    exp_q.delete();
    m_hi = '0; m_lo = '0;
    busy_until = -1; t_last = -100; n_last = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(12);

    // Narrow instance, single-cycle multiply and two-cycle divide.
    s2 = 1'b1; op2 = 3'd0; a2 = 16'h0100; b2 = 16'h0100;
    #1;
    check("w16_stall", 32'(stall2), 32'd1);
    idle(1);
    s2 = 1'b0;
    check("w16_busy", 32'(busy2), 32'd1);
    check("w16_hi_hold", 32'(hi2), 32'd0);
    idle(1);
    check("w16_busy_end", 32'(busy2), 32'd0);
    check("w16_done", 32'(done2), 32'd1);
    check("w16_hi", 32'(hi2), 32'h0001);
    check("w16_lo", 32'(lo2), 32'h0000);
    idle(1);
    check("w16_done_pulse", 32'(done2), 32'd0);
    s2 = 1'b1; op2 = 3'd2; a2 = 16'hFFF9; b2 = 16'd2;
    idle(1);
    s2 = 1'b0;
    idle(1);
    check("w16_div_busy", 32'(busy2), 32'd1);
    check("w16_div_lo_hold", 32'(lo2), 32'h0000);
    idle(1);
    check("w16_div_done", 32'(done2), 32'd1);
    check("w16_div_lo", 32'(lo2), 32'hFFFD);
    check("w16_div_hi", 32'(hi2), 32'hFFFF);

    // Randomised traffic, including starts during RUN and ops 6-7.
    for (int i = 0; i < 600; i++) begin
      if ($urandom % 3 == 0) drive(1'b1, 3'($urandom % 8), rnd_a(), rnd_b());
      else drive(1'b0, 3'($urandom % 8), rnd_a(), rnd_b());
    end
    idle(15);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Parametrised multiply/divide unit with HI/LO registers for the EX stage of the 5-stage MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU over a configurable number of cycles and handles MTHI/MTLO writes.
- Exposes a stall request that the hazard controller uses to freeze IF/ID and bubble ID/EX while an operation is outstanding.
- Provides HI/LO read values for MFHI/MFLO.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (>=4)
MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low; clears all state immediately
start  input  1  EX-stage instruction is a md op this cycle (qualified by op)
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
a  input  WIDTH  rs operand (forwarded value)
b  input  WIDTH  rt operand (forwarded value)
busy  output  1  registered; operation in flight
done  output  1  registered one-cycle pulse after result commit
stall  output  1  combinational: busy | (start & op<=3)
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset==0, asynchronous): hi=0, lo=0, busy=0, done=0, count=0, state IDLE. Reset mid-operation aborts it; hi/lo do not receive the pending result.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, down-counter active.
- IDLE transitions:
  - start & op in {0..3} at edge T: latch a, b, op; count loaded with N-1 (N=MULT_CYCLES or DIV_CYCLES); go to RUN.
  - busy=1 for exactly N cycles (after edge T through edge T+N).
  - At edge T+N: hi/lo commit, busy->0, done=1 for one cycle, return to IDLE.
- MTHI/MTLO in IDLE: hi (op 4) or lo (op 5) <= a at the same edge. No busy, no done; the other register is unchanged.
- start in RUN: ignored entirely, including MTHI/MTLO and ops 0-3. Operands are taken only from latched copies. The hazard controller guarantees no md op issues while stall=1; the unit does not queue.
- op 6-7 with start: no effect in any state.
- MULT: signed 2*WIDTH product; hi = upper WIDTH bits, lo = lower WIDTH bits.
- MULTU: same, with both operands unsigned.
- DIV: signed, quotient truncated toward zero; lo = quotient, hi = remainder (sign of dividend).
- DIVU: unsigned; lo = quotient, hi = remainder.
- Divide by zero (b==0): lo = all ones, hi = a. Takes full DIV_CYCLES.
- Signed overflow (DIV, a = most negative, b = -1): lo = a, hi = 0.
- Implementation may compute iteratively (shift-add / restoring division) or combinationally. Results must not be visible on hi/lo before edge T+N.
- hi/lo always reflect committed state; MFHI/MFLO read them directly.
- done and busy never both high in the same cycle.
- stall in IDLE equals (start & op<=3), so the issuing cycle already holds the following instruction in ID.

Test Plan:
- Reset release, no start -> hi=0, lo=0, busy=0, done=0, stall=0. MTHI a=0x12345678 -> next cycle hi=0x12345678, lo=0, busy never set.
- MULT a=7, b=0xFFFFFFFD (-3) -> busy high exactly 5 cycles; at commit hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses one cycle. MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- DIV b=0, a=0x55 -> lo=0xFFFFFFFF, hi=0x55. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT issued, then start with MTLO a=0xAAAA at cycle 2 and MULT a=3, b=3 at cycle 3 -> both ignored; final lo is the first product; busy length unchanged; stall=1 throughout.
- DIV in flight, reset pulled low at cycle 4 -> busy=0 and hi=lo=0 immediately; after release no done pulse, state IDLE. Repeat with WIDTH=16, MULT_CYCLES=1: MULT 0x0100*0x0100 -> hi=0x0001, lo=0x0000 after one busy cycle.
